uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: DATA_WIDTH, default 8, number of data bits per frame.
REQ-002 Port: CLK  input  1  sampling clock, Prescale times the bit rate; only clock in the block.
REQ-003 Port: RST  input  1  reset, synchronous, active-high.
REQ-004 Port: RX_IN  input  1  serial line; idle high.
REQ-005 Port: PAR_EN  input  1  1 = parity bit present in frame.
REQ-006 Port: PAR_TYP  input  1  0 = even parity, 1 = odd parity.
REQ-007 Port: Prescale  input  6  CLK cycles per bit; legal values 8, 16, 32.
REQ-008 Port: P_DATA  output  DATA_WIDTH  last correctly received data word.
REQ-009 Port: Data_Valid  output  1  one-cycle pulse when P_DATA is updated.
REQ-010 Port: Par_Err  output  1  one-cycle pulse on parity mismatch.
REQ-011 Port: Stop_Err  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-012 The block SHALL implement the FSM IDLE -> START -> DATA -> PARITY -> STOP -> IDLE; PARITY is entered only when PAR_EN=1.
REQ-013 IDLE -> START SHALL occur on the first CLK edge at which RX_IN=0; edge counter cleared to 0.
REQ-014 The edge counter SHALL run 0..Prescale-1 per bit, wrap to 0, and the bit counter SHALL increment on each wrap.
REQ-015 Each bit value SHALL be the 2-of-3 majority of RX_IN at edge counts Prescale/2-1, Prescale/2, and Prescale/2+1.
REQ-016 If the start-bit sample is 1 (glitch), the FSM SHALL return to IDLE at edge Prescale-1 with no output pulses.
REQ-017 DATA SHALL shift in DATA_WIDTH bits LSB first into an internal register; P_DATA SHALL NOT change during reception.
REQ-018 The parity check SHALL compare the received parity bit against XOR(data) for even or ~XOR(data) for odd, per the PAR_EN and PAR_TYP values sampled at start-bit detection.
REQ-019 At STOP edge count Prescale-1 the block SHALL evaluate the frame:
- no error: P_DATA <= received word and Data_Valid=1 for exactly one cycle;
- parity error: Par_Err=1 for one cycle;
- stop bit 0: Stop_Err=1 for one cycle.
- Both errors may pulse together; on any error Data_Valid SHALL stay 0 and P_DATA SHALL hold.
REQ-020 From that STOP cycle, if RX_IN=0, the FSM SHALL go directly to START (back-to-back frames without an idle cycle); otherwise it SHALL go to IDLE.
REQ-021 Prescale values other than 8, 16, or 32 SHALL be treated as 8.
REQ-022 Changes to Prescale, PAR_EN, or PAR_TYP mid-frame SHALL take effect from the next start detection.

Reset
REQ-023 With RST=1 at a CLK edge, the FSM SHALL go to IDLE; counters SHALL clear; P_DATA=0; and Data_Valid, Par_Err, and Stop_Err SHALL be 0.
REQ-024 Reset mid-frame SHALL abandon the frame with no pulses; reception SHALL restart on the first RX_IN=0 after RST falls.

Configuration
REQ-025 Macro UART_RX_PARITY_EN: when defined, the PARITY state and the parity checker SHALL be present per REQ-012/018.
REQ-026 When UART_RX_PARITY_EN is undefined, PAR_EN and PAR_TYP SHALL be ignored, frames SHALL be start+data+stop only, and Par_Err SHALL be tied to 0.

Verification
REQ-027 Prescale=8, PAR_EN=0, frame 0xA5 -> Data_Valid pulse one cycle after stop edge 7, P_DATA=0xA5, no errors.
REQ-028 Prescale=16, PAR_EN=1, PAR_TYP=0, data 0x3C with parity 1 (wrong) -> Par_Err pulse, no Data_Valid, P_DATA holds its previous value.
REQ-029 Prescale=32, stop bit driven 0, frame 0x81 -> Stop_Err pulse, FSM returns to IDLE.
REQ-030 RX_IN low for 2 cycles only (Prescale=8) -> no pulses, FSM back in IDLE by edge 7.
REQ-031 Two back-to-back frames 0x55 then 0xAA (Prescale=16, PAR_TYP=1) -> two Data_Valid pulses exactly 11 bit periods apart, values in order.
REQ-032 RST asserted during data bit 4, then frame 0x0F -> no pulse for the aborted frame, P_DATA=0x0F after the second frame.

Source files
------------

// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver with 3-sample majority voting; parity support enabled by UART_RX_PARITY_EN
module uart_rx #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    input  logic [5:0]            Prescale,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  Data_Valid,
    output logic                  Par_Err,
    output logic                  Stop_Err
);
    localparam int BW = $clog2(DATA_WIDTH + 3);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    state_t                state_q, state_d;
    logic [5:0]            edge_q, edge_d, pre_q, pre_d, pre_sel, half;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  s0_q, s0_d, s1_q, s1_d, smp_q, smp_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d, data_q, data_d;
    logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d;
    logic                  wrap, start_det, par_on, par_bad;
    assign pre_sel   = (Prescale == 6'd16 || Prescale == 6'd32) ? Prescale : 6'd8;
    assign half      = {1'b0, pre_q[5:1]};
    assign wrap      = edge_q == pre_q - 6'd1;
    assign start_det = !RX_IN && (state_q == IDLE || (state_q == STOP && wrap));
`ifdef UART_RX_PARITY_EN
    logic par_en_q, par_typ_q, par_bit_q;
    // Latch parity configuration at start detection and capture the received parity bit
    always_ff @(posedge CLK) begin
        if (RST) begin
            par_en_q  <= 1'b0;
            par_typ_q <= 1'b0;
            par_bit_q <= 1'b0;
        end else begin
            if (start_det) begin
                par_en_q  <= PAR_EN;
                par_typ_q <= PAR_TYP;
            end
            if (state_q == PARITY && wrap) par_bit_q <= smp_q;
        end
    end
    assign par_on  = par_en_q;
    assign par_bad = par_en_q && (par_bit_q != (^shift_q ^ par_typ_q));
`else
    logic unused_par;
    assign unused_par = PAR_EN ^ PAR_TYP;
    assign par_on     = 1'b0;
    assign par_bad    = 1'b0;
`endif
    // Next-state logic: per-bit edge counting, mid-bit majority vote, frame sequencing and evaluation
    always_comb begin
        state_d = state_q;
        edge_d  = edge_q + 6'd1;
        bit_d   = bit_q;
        pre_d   = pre_q;
        s0_d    = s0_q;
        s1_d    = s1_q;
        smp_d   = smp_q;
        shift_d = shift_q;
        data_d  = data_q;
        dv_d    = 1'b0;
        pe_d    = 1'b0;
        se_d    = 1'b0;
        if (edge_q == half - 6'd1) s0_d = RX_IN;
        if (edge_q == half) s1_d = RX_IN;
        if (edge_q == half + 6'd1) smp_d = (s0_q & s1_q) | (s0_q & RX_IN) | (s1_q & RX_IN);
        if (wrap) begin
            edge_d = 6'd0;
            bit_d  = bit_q + BW'(1);
        end
        case (state_q)
            IDLE: begin
                edge_d = 6'd0;
                bit_d  = '0;
            end
            START:  if (wrap) state_d = smp_q ? IDLE : DATA;
            DATA: if (wrap) begin
                shift_d = {smp_q, shift_q[DATA_WIDTH-1:1]};
                if (bit_q == BW'(DATA_WIDTH)) state_d = par_on ? PARITY : STOP;
            end
            PARITY: if (wrap) state_d = STOP;
            STOP: if (wrap) begin
                state_d = IDLE;
                dv_d    = smp_q && !par_bad;
                pe_d    = par_bad;
                se_d    = !smp_q;
                data_d  = (smp_q && !par_bad) ? shift_q : data_q;
            end
            default: state_d = IDLE;
        endcase
        if (start_det) begin
            state_d = START;
            edge_d  = 6'd0;
            bit_d   = '0;
            pre_d   = pre_sel;
        end
    end
    // State register with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            edge_q  <= 6'd0;
            bit_q   <= '0;
            pre_q   <= 6'd8;
            s0_q    <= 1'b1;
            s1_q    <= 1'b1;
            smp_q   <= 1'b1;
            shift_q <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            pe_q    <= 1'b0;
            se_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            edge_q  <= edge_d;
            bit_q   <= bit_d;
            pre_q   <= pre_d;
            s0_q    <= s0_d;
            s1_q    <= s1_d;
            smp_q   <= smp_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            pe_q    <= pe_d;
            se_q    <= se_d;
        end
    end
    assign P_DATA     = data_q;
    assign Data_Valid = dv_q;
    assign Par_Err    = pe_q;
    assign Stop_Err   = se_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: vector table, directed corner sequences and randomized frames checked against a frame-level model
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int W = 8;
`ifdef UART_RX_PARITY_EN
    localparam bit HAS_PAR = 1'b1;
`else
    localparam bit HAS_PAR = 1'b0;
`endif
    logic CLK = 1'b0, RST = 1'b1, RX_IN = 1'b1, PAR_EN = 1'b0, PAR_TYP = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic [W-1:0] P_DATA;
    logic Data_Valid, Par_Err, Stop_Err;

    uart_rx #(.DATA_WIDTH(W)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .PAR_TYP(PAR_TYP),
        .Prescale(Prescale), .P_DATA(P_DATA), .Data_Valid(Data_Valid),
        .Par_Err(Par_Err), .Stop_Err(Stop_Err)
    );

    always #5 CLK = ~CLK;

    typedef struct {int when; bit dv; bit pe; bit se; logic [W-1:0] data;} ev_t;
    typedef struct {
        logic [5:0] ps; bit pen; bit ptyp; logic [W-1:0] d;
        bit bad_par; bit bad_stop; int gap; bit edv; bit epe; bit ese;
    } vec_t;

    int checks = 0, failures = 0, cyc = 0;
    ev_t exp_q[$];
    ev_t mon_e;
    int dv_times[$];
    logic [W-1:0] model_data = '0;
    vec_t vecs[9];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Pulse monitor: every pulse must match the next predicted frame outcome in time and kind
    always @(negedge CLK) if (!RST) begin
        if (Data_Valid || Par_Err || Stop_Err) begin
            if (exp_q.size() == 0) check("unexpected_pulse", {Data_Valid, Par_Err, Stop_Err}, 0);
            else begin
                mon_e = exp_q.pop_front();
                check("pulse_time", cyc, mon_e.when);
                check("pulse_flags", {Data_Valid, Par_Err, Stop_Err}, {mon_e.dv, mon_e.pe, mon_e.se});
                if (mon_e.dv) begin
                    model_data = mon_e.data;
                    dv_times.push_back(cyc);
                end
            end
        end else if (exp_q.size() != 0 && cyc > exp_q[0].when) begin
            check("missed_pulse", cyc, exp_q[0].when);
            mon_e = exp_q.pop_front();
        end
        check("p_data", P_DATA, model_data);
    end

    task automatic idle(input int n);
        RX_IN = 1'b1;
        repeat (n) @(negedge CLK);
    endtask

    task automatic send_frame(input logic [5:0] ps, input bit pen, input bit ptyp, input logic [W-1:0] d,
                              input bit bad_par, input bit bad_stop, input bit scramble,
                              input bit edv, input bit epe, input bit ese);
        int p, nb;
        bit has_p, pbit;
        p = (ps == 6'd16 || ps == 6'd32) ? int'(ps) : 8;
        has_p = HAS_PAR && pen;
        nb = W + 2 + (has_p ? 1 : 0);
        pbit = (^d) ^ ptyp ^ bad_par;
        Prescale = ps;
        PAR_EN = pen;
        PAR_TYP = ptyp;
        if (edv || epe || ese) exp_q.push_back('{cyc + 1 + nb * p, edv, epe, ese, d});
        RX_IN = 1'b0;
        repeat (p) @(negedge CLK);
        if (scramble) begin
            Prescale = 6'($urandom);
            PAR_EN = 1'($urandom);
            PAR_TYP = 1'($urandom);
        end
        for (int i = 0; i < W; i++) begin
            RX_IN = d[i];
            repeat (p) @(negedge CLK);
        end
        if (has_p) begin
            RX_IN = pbit;
            repeat (p) @(negedge CLK);
        end
        RX_IN = !bad_stop;
        repeat (p) @(negedge CLK);
    endtask

    initial begin
        int n0, bound;
        logic [5:0] ps;
        bit pen, ptyp, bp, bs, has_p, epe;
        logic [W-1:0] d;
        vecs[0] = '{6'd8,  1'b0, 1'b0, 8'hA5, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{6'd16, 1'b1, 1'b0, 8'h3C, 1'b1, 1'b0, 2, !HAS_PAR, HAS_PAR, 1'b0};
        vecs[2] = '{6'd32, 1'b0, 1'b0, 8'h81, 1'b0, 1'b1, 3, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{6'd16, 1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 0, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{6'd16, 1'b1, 1'b1, 8'hAA, 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{6'd12, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{6'd8,  1'b1, 1'b0, 8'h01, 1'b1, 1'b1, 2, 1'b0, HAS_PAR, 1'b1};
        vecs[7] = '{6'd0,  1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{6'd32, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0, 2, 1'b1, 1'b0, 1'b0};
        repeat (3) @(negedge CLK);
        check("reset_outputs", {P_DATA, Data_Valid, Par_Err, Stop_Err}, 0);
        RST = 1'b0;
        idle(3);
        n0 = 0;
        for (int v = 0; v < 9; v++) begin
            if (v == 3) n0 = dv_times.size();
            send_frame(vecs[v].ps, vecs[v].pen, vecs[v].ptyp, vecs[v].d, vecs[v].bad_par,
                       vecs[v].bad_stop, 1'b0, vecs[v].edv, vecs[v].epe, vecs[v].ese);
            idle(vecs[v].gap);
            if (v == 4) begin
                check("b2b_count", dv_times.size() - n0, 2);
                if (dv_times.size() - n0 == 2)
                    check("b2b_spacing", dv_times[n0 + 1] - dv_times[n0], (HAS_PAR ? 11 : 10) * 16);
            end
        end
        Prescale = 6'd8;
        PAR_EN = 1'b0;
        RX_IN = 1'b0;
        repeat (2) @(negedge CLK);
        idle(7);
        send_frame(6'd8, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("glitch_then_frame", P_DATA, 8'h5A);
        RX_IN = 1'b0;
        repeat (8) @(negedge CLK);
        RX_IN = 1'b1;
        repeat (36) @(negedge CLK);
        RST = 1'b1;
        model_data = '0;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        check("midframe_reset", {P_DATA, Data_Valid, Par_Err, Stop_Err}, 0);
        idle(3);
        send_frame(6'd8, 1'b0, 1'b0, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
        idle(2);
        check("after_reset_frame", P_DATA, 8'h0F);
        for (int k = 0; k < 120; k++) begin
            case ($urandom_range(0, 3))
                0: ps = 6'd8;
                1: ps = 6'd16;
                2: ps = 6'd32;
                default: ps = 6'($urandom);
            endcase
            pen = 1'($urandom);
            ptyp = 1'($urandom);
            d = W'($urandom);
            bp = ($urandom_range(0, 3) == 0);
            bs = ($urandom_range(0, 4) == 0);
            has_p = HAS_PAR && pen;
            epe = has_p && bp;
            send_frame(ps, pen, ptyp, d, bp, bs, 1'b1, !epe && !bs, epe, bs);
            idle($urandom_range(0, 4));
        end
        idle(2);
        bound = 0;
        while (exp_q.size() != 0 && bound < 2000) begin
            @(negedge CLK);
            bound++;
        end
        check("drain", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
